// File: rtl/i2s_rx_ws_deser.sv
// Slave-side I2S receive front end: WS edge detection, word deserialisation and a
// 2-entry {channel, data} output buffer. Define I2S_RX_SIGN_EXT_EN to sign-extend words.
`timescale 1ns/1ps

module i2s_rx_ws_deser (
  input  logic        sck_i,
  input  logic        rstn_i,
  input  logic        cfg_en_i,
  input  logic [4:0]  cfg_data_size_i,
  input  logic        cfg_lsb_first_i,
  input  logic        ws_i,
  input  logic        sd_i,
  output logic [31:0] data_o,
  output logic        data_ch_o,
  output logic        data_valid_o,
  input  logic        data_ready_i,
  output logic        overflow_o,
  output logic        word_err_o
);

  typedef enum logic [1:0] {IDLE, SHIFT, WAIT} state_e;

  state_e      state_q, state_d;
  logic        ws_q, ws_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        ch_q, ch_d;
  logic [31:0] sr_q, sr_d;
  logic [31:0] buf_data_q [2];
  logic [31:0] buf_data_d [2];
  logic [1:0]  buf_ch_q, buf_ch_d;
  logic [1:0]  count_q, count_d;
  logic        ovf_q, ovf_d;
  logic        err_q, err_d;

  logic        ws_edge;
  logic        last_bit;
  logic        push;
  logic        pop;
  logic [31:0] sr_shift;
  logic [31:0] mask;
  logic [31:0] word_raw;
  logic [31:0] word;

  assign ws_edge  = cfg_en_i && (ws_i != ws_q);
  assign last_bit = (cnt_q == cfg_data_size_i);
  assign sr_shift = cfg_lsb_first_i ? (sr_q | (32'(sd_i) << cnt_q))
                                    : {sr_q[30:0], sd_i};
  assign mask     = 32'hFFFF_FFFF >> (5'd31 - cfg_data_size_i);
  assign word_raw = sr_shift & mask;

`ifdef I2S_RX_SIGN_EXT_EN
  assign word = word_raw | (~mask & {32{word_raw[cfg_data_size_i]}});
`else
  assign word = word_raw;
`endif

  // Slot tracking: the edge cycle itself still carries the previous word's last bit.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    state_d = state_q;
    ws_d    = ws_i;
    cnt_d   = cnt_q;
    ch_d    = ch_q;
    sr_d    = sr_q;
    push    = 1'b0;
    err_d   = 1'b0;
    if (!cfg_en_i) begin
      state_d = IDLE;
      cnt_d   = '0;
      sr_d    = '0;
    end else begin
      case (state_q)
        IDLE, WAIT: begin
          if (ws_edge) begin
            state_d = SHIFT;
            cnt_d   = '0;
            sr_d    = '0;
            ch_d    = ws_i;
          end
        end
        SHIFT: begin
          push = last_bit;
          if (ws_edge) begin
            err_d   = !last_bit;
            state_d = SHIFT;
            cnt_d   = '0;
            sr_d    = '0;
            ch_d    = ws_i;
          end else if (last_bit) begin
            state_d = WAIT;
          end else begin
            sr_d  = sr_shift;
            cnt_d = cnt_q + 5'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign pop = data_valid_o && data_ready_i;

  // Entry 0 is always the head; a pop moves entry 1 down.
  always_comb begin
    buf_data_d = buf_data_q;
    buf_ch_d   = buf_ch_q;
    count_d    = count_q;
    ovf_d      = ovf_q;
    if (!cfg_en_i) begin
      count_d = '0;
      ovf_d   = 1'b0;
    end else begin
      case (count_q)
        2'd0: begin
          if (push) begin
            buf_data_d[0] = word;
            buf_ch_d[0]   = ch_q;
            count_d       = 2'd1;
          end
        end
        2'd1: begin
          if (push && pop) begin
            buf_data_d[0] = word;
            buf_ch_d[0]   = ch_q;
          end else if (push) begin
            buf_data_d[1] = word;
            buf_ch_d[1]   = ch_q;
            count_d       = 2'd2;
          end else if (pop) begin
            count_d = 2'd0;
          end
        end
        default: begin
          if (pop) begin
            buf_data_d[0] = buf_data_q[1];
            buf_ch_d[0]   = buf_ch_q[1];
            if (push) begin
              buf_data_d[1] = word;
              buf_ch_d[1]   = ch_q;
            end else begin
              count_d = 2'd1;
            end
          end else if (push) begin
            ovf_d = 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge sck_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q    <= IDLE;
      ws_q       <= 1'b0;
      cnt_q      <= '0;
      ch_q       <= 1'b0;
      sr_q       <= '0;
      // NOTE: the buffer storage is reset because data_o exposes it and must read 0 after reset.
      buf_data_q <= '{default: '0};
      buf_ch_q   <= '0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
      state_q    <= state_d;
      ws_q       <= ws_d;
      cnt_q      <= cnt_d;
      ch_q       <= ch_d;
      sr_q       <= sr_d;
      buf_data_q <= buf_data_d;
      buf_ch_q   <= buf_ch_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
      err_q      <= err_d;
    end
  end

  assign data_o       = buf_data_q[0];
  assign data_ch_o    = buf_ch_q[0];
  assign data_valid_o = (count_q != 2'd0);
  assign overflow_o   = ovf_q;
  assign word_err_o   = err_q;

endmodule

// File: tb/tb_i2s_rx_ws_deser.sv
// Directed bench for i2s_rx_ws_deser: slot-level stimulus annotates where words complete,
// a queue model of the buffer is compared every cycle, and literal results pin each scenario.
`timescale 1ns/1ps

module tb_i2s_rx_ws_deser;

  logic        sck_i = 1'b0;
  logic        rstn_i = 1'b0;
  logic        cfg_en_i = 1'b0;
  logic [4:0]  cfg_data_size_i = 5'd0;
  logic        cfg_lsb_first_i = 1'b0;
  logic        ws_i = 1'b0;
  logic        sd_i = 1'b0;
  logic        data_ready_i = 1'b0;
  logic [31:0] data_o;
  logic        data_ch_o;
  logic        data_valid_o;
  logic        overflow_o;
  logic        word_err_o;

  i2s_rx_ws_deser dut (
    .sck_i           (sck_i),
    .rstn_i          (rstn_i),
    .cfg_en_i        (cfg_en_i),
    .cfg_data_size_i (cfg_data_size_i),
    .cfg_lsb_first_i (cfg_lsb_first_i),
    .ws_i            (ws_i),
    .sd_i            (sd_i),
    .data_o          (data_o),
    .data_ch_o       (data_ch_o),
    .data_valid_o    (data_valid_o),
    .data_ready_i    (data_ready_i),
    .overflow_o      (overflow_o),
    .word_err_o      (word_err_o)
  );

  always #5 sck_i = ~sck_i;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected word: low size+1 bits of w, upper bits zero or copies of bit 'size'.
  function automatic logic [31:0] exp_word(input logic [31:0] w, input int size);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      if (i <= size) r[i] = w[i];
      else begin
`ifdef I2S_RX_SIGN_EXT_EN
        r[i] = w[size];
`else
        r[i] = 1'b0;
`endif
      end
    end
    return r;
  endfunction

  // Annotations for the cycle being driven: what the DUT should conclude at the next posedge.
  logic        ann_push = 1'b0;
  logic        ann_err = 1'b0;
  logic        ann_ch = 1'b0;
  logic [31:0] ann_data = '0;

  logic [32:0] mq[$];
  logic        exp_err = 1'b0;
  logic        exp_ovf = 1'b0;
  logic        m_pop;
  logic        m_full;
  logic        chk_en = 1'b0;
  logic [32:0] got[$];
  int          err_cycles = 0;

  always @(posedge sck_i or negedge rstn_i) begin
    if (!rstn_i) begin
      mq.delete();
      exp_err = 1'b0;
      exp_ovf = 1'b0;
    end else if (!cfg_en_i) begin
      mq.delete();
      exp_err = 1'b0;
      exp_ovf = 1'b0;
    end else begin
      m_pop  = (mq.size() != 0) && data_ready_i;
      m_full = (mq.size() == 2);
      exp_err = ann_err;
      if (ann_push && m_full && !m_pop) exp_ovf = 1'b1;
      if (m_pop) void'(mq.pop_front());
      if (ann_push && !(m_full && !m_pop)) mq.push_back({ann_ch, ann_data});
    end
  end

  always @(negedge sck_i) begin
    if (chk_en) begin
      check("valid", 32'(data_valid_o), 32'(mq.size() != 0));
      if (mq.size() != 0) begin
        check("data", data_o, mq[0][31:0]);
        check("ch", 32'(data_ch_o), 32'(mq[0][32]));
      end
      check("word_err", 32'(word_err_o), 32'(exp_err));
      check("overflow", 32'(overflow_o), 32'(exp_ovf));
    end
    if (rstn_i && data_valid_o && data_ready_i) got.push_back({data_ch_o, data_o});
    if (word_err_o) err_cycles++;
  end

  task automatic cyc_ann(input logic ws, input logic sd, input logic push,
                         input logic [31:0] pdata, input logic pch, input logic err);
    @(posedge sck_i);
    #2;
    ws_i     = ws;
    sd_i     = sd;
    ann_push = push;
    ann_data = pdata;
    ann_ch   = pch;
    ann_err  = err;
  endtask

  task automatic cyc(input logic ws, input logic sd);
    cyc_ann(ws, sd, 1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  // One slot on channel ch; its last cycle already carries next_ws (I2S one-bit delay).
  task automatic slot(input logic ch, input logic [31:0] w, input int size, input int slot_len,
                      input logic pad, input logic next_ws, input logic rdy_last);
    for (int j = 0; j < slot_len; j++) begin
      logic b, ws, p, e;
      ws = (j == slot_len - 1) ? next_ws : ch;
      if (j <= size) b = cfg_lsb_first_i ? w[j] : w[size - j];
      else           b = pad;
      p = (j == size);
      e = (j == slot_len - 1) && (j < size) && (next_ws != ch);
      cyc_ann(ws, b, p, exp_word(w, size), ch, e);
      if (rdy_last && j == size) data_ready_i = 1'b1;
    end
  endtask

  // Flush, enable with WS steady on ~ch, then produce the edge that starts channel ch.
  task automatic lead(input logic ch);
    cfg_en_i = 1'b0;
    cyc(~ch, 1'b0);
    cyc(~ch, 1'b0);
    cfg_en_i = 1'b1;
    cyc(~ch, 1'b0);
    cyc(ch, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(ws_i, 1'b0);
  endtask

  task automatic check_got(input string name, input int idx, input logic ch, input logic [31:0] data);
    logic [32:0] e;
    e = (idx < got.size()) ? got[idx] : {1'b1, 32'hBAD0_BAD0};
    check({name, "_data"}, e[31:0], data);
    check({name, "_ch"}, 32'(e[32]), 32'(ch));
  endtask

  initial begin
    repeat (2) @(posedge sck_i);
    #2;
    check("rst_data", data_o, 32'h0);
    check("rst_ch", 32'(data_ch_o), 32'h0);
    check("rst_valid", 32'(data_valid_o), 32'h0);
    check("rst_ovf", 32'(overflow_o), 32'h0);
    check("rst_err", 32'(word_err_o), 32'h0);
    chk_en = 1'b1;
    rstn_i = 1'b1;

    // MSB-first, 16-bit words in 16-bit slots.
    cfg_data_size_i = 5'd15;
    cfg_lsb_first_i = 1'b0;
    data_ready_i = 1'b1;
    got.delete();
    lead(1'b0);
    slot(1'b0, 32'hA5C3, 15, 16, 1'b0, 1'b1, 1'b0);
    slot(1'b1, 32'h1234, 15, 16, 1'b0, 1'b1, 1'b0);
    idle(4);
    check("t1_count", got.size(), 32'd2);
    check_got("t1_w0", 0, 1'b0, 32'h0000A5C3);
    check_got("t1_w1", 1, 1'b1, 32'h00001234);

    // LSB-first, 8-bit words in 32-bit slots padded with ones.
    cfg_data_size_i = 5'd7;
    cfg_lsb_first_i = 1'b1;
    got.delete();
    lead(1'b0);
    slot(1'b0, 32'h81, 7, 32, 1'b1, 1'b1, 1'b0);
    slot(1'b1, 32'h5A, 7, 32, 1'b1, 1'b1, 1'b0);
    idle(4);
    check("t2_count", got.size(), 32'd2);
    check_got("t2_w0", 0, 1'b0, 32'h00000081);
    check_got("t2_w1", 1, 1'b1, 32'h0000005A);

    // Early WS edge after 11 bits of a 16-bit word.
    cfg_data_size_i = 5'd15;
    cfg_lsb_first_i = 1'b0;
    got.delete();
    lead(1'b1);
    err_cycles = 0;
    slot(1'b1, 32'hFFFF, 15, 11, 1'b0, 1'b0, 1'b0);
    slot(1'b0, 32'hBEEF, 15, 16, 1'b0, 1'b0, 1'b0);
    idle(4);
    check("t3_err_cycles", err_cycles, 32'd1);
    check("t3_count", got.size(), 32'd1);
    check_got("t3_w0", 0, 1'b0, 32'h0000BEEF);

    // Overflow: third word dropped while the consumer stalls.
    cfg_data_size_i = 5'd7;
    data_ready_i = 1'b0;
    got.delete();
    lead(1'b0);
    slot(1'b0, 32'h11, 7, 8, 1'b0, 1'b1, 1'b0);
    slot(1'b1, 32'h22, 7, 8, 1'b0, 1'b0, 1'b0);
    slot(1'b0, 32'h33, 7, 8, 1'b0, 1'b0, 1'b0);
    idle(3);
    check("t4_ovf_set", 32'(overflow_o), 32'h1);
    check("t4_head_held", data_o, 32'h11);
    data_ready_i = 1'b1;
    idle(4);
    check("t4_count", got.size(), 32'd2);
    check_got("t4_w0", 0, 1'b0, 32'h11);
    check_got("t4_w1", 1, 1'b1, 32'h22);
    check("t4_ovf_sticky", 32'(overflow_o), 32'h1);
    cfg_en_i = 1'b0;
    idle(1);
    check("t4_ovf_clear", 32'(overflow_o), 32'h0);

    // Full buffer, third push coincides with a pop.
    data_ready_i = 1'b0;
    got.delete();
    lead(1'b0);
    slot(1'b0, 32'h11, 7, 8, 1'b0, 1'b1, 1'b0);
    slot(1'b1, 32'h22, 7, 8, 1'b0, 1'b0, 1'b0);
    slot(1'b0, 32'h33, 7, 8, 1'b0, 1'b0, 1'b1);
    idle(4);
    check("t4b_ovf", 32'(overflow_o), 32'h0);
    check("t4b_count", got.size(), 32'd3);
    check_got("t4b_w2", 2, 1'b0, 32'h33);

    // Enable raised halfway through a slot.
    cfg_data_size_i = 5'd15;
    data_ready_i = 1'b1;
    cfg_en_i = 1'b0;
    got.delete();
    idle(2);
    cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b0);
    for (int j = 0; j < 16; j++) begin
      cyc((j == 15) ? 1'b1 : 1'b0, j[0]);
      if (j == 7) cfg_en_i = 1'b1;
    end
    slot(1'b1, 32'h6E5D, 15, 16, 1'b0, 1'b1, 1'b0);
    idle(4);
    check("t5_count", got.size(), 32'd1);
    check_got("t5_w0", 0, 1'b1, 32'h00006E5D);

    // Word 0x80 at size 7: sign extension only when the macro is defined.
    cfg_data_size_i = 5'd7;
    got.delete();
    lead(1'b1);
    slot(1'b1, 32'h80, 7, 8, 1'b0, 1'b1, 1'b0);
    idle(4);
`ifdef I2S_RX_SIGN_EXT_EN
    check_got("t6_w0", 0, 1'b1, 32'hFFFFFF80);
`else
    check_got("t6_w0", 0, 1'b1, 32'h00000080);
`endif

    // Asynchronous reset with a word pending.
    data_ready_i = 1'b0;
    lead(1'b0);
    slot(1'b0, 32'h3C, 7, 8, 1'b0, 1'b0, 1'b0);
    idle(1);
    check("t7_pending", 32'(data_valid_o), 32'h1);
    rstn_i = 1'b0;
    #1;
    check("t7_rst_valid", 32'(data_valid_o), 32'h0);
    check("t7_rst_data", data_o, 32'h0);
    cfg_en_i = 1'b0;
    idle(2);
    rstn_i = 1'b1;
    idle(2);
    check("t7_post_valid", 32'(data_valid_o), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
